// File: rtl/flash_region_attr_gen_pkg.sv
// Shared package for the flash region attribute producer and its consumer.
// It holds the enable/phase encodings, the attribute word layout and the
// reset value of the attribute output register. It also holds a helper that
// builds one attribute word from a phase and a bank enable.
package pkg;

  // Multi-bit boolean. Only these two codes are legal in an enable register.
  typedef enum logic [3:0] {
    true_e  = 4'h6,
    false_e = 4'h9
  } enum_t;

  typedef enum logic [1:0] {
    seed_e    = 2'b00,
    rma_e     = 2'b01,
    none_e    = 2'b10,
    invalid_e = 2'b11
  } phase_t;

  typedef struct packed {
    enum_t en;
  } region_cfg_t;

  typedef struct packed {
    phase_t      phase;
    region_cfg_t cfg;
  } region_attr_t;

  localparam int NumBanks     = 2;
  localparam int PagesPerBank = 64;

  localparam region_attr_t AttrResetVal = '{phase: none_e, cfg: '{en: false_e}};

  // The RMA phase unlocks every page, whatever the bank register holds.
  function automatic region_attr_t make_attr(input phase_t phase, input enum_t en);
    region_attr_t a;
    a.phase  = phase;
    a.cfg.en = (phase == rma_e) ? true_e : en;
    return a;
  endfunction

endpackage

// File: rtl/flash_region_attr_gen_walker.sv
// flash_page_walker: bank/page counters for the attribute walk.
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   clear_i          return both counters to bank 0 / page 0
//   advance_i        step to the next (bank, page) pair
//   bank_o, page_o   index of the word currently presented
//   next_bank_o,
//   next_page_o      index that advance_i will move to
//   last_o           current index is the final word of the walk
module flash_page_walker #(
  parameter int NumBanks     = 2,
  parameter int PagesPerBank = 64,
  parameter int BankW        = 1,
  parameter int PageW        = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [BankW-1:0] bank_o,
  output logic [PageW-1:0] page_o,
  output logic [BankW-1:0] next_bank_o,
  output logic [PageW-1:0] next_page_o,
  output logic             last_o
);

  logic [BankW-1:0] bank_q;
  logic [PageW-1:0] page_q;
  logic             last_page;

  assign last_page = (page_q == PageW'(PagesPerBank - 1));
  assign last_o    = last_page && (bank_q == BankW'(NumBanks - 1));

  // The page wraps to 0 and carries into the bank at the end of each bank.
  always_comb begin
    next_bank_o = bank_q;
    next_page_o = page_q + PageW'(1);
    if (last_page) begin
      next_page_o = '0;
      next_bank_o = bank_q + BankW'(1);
    end
  end

  // Clear has priority, so a start can never inherit a stale index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q <= '0;
      page_q <= '0;
    end else if (clear_i) begin
      bank_q <= '0;
      page_q <= '0;
    end else if (advance_i) begin
      bank_q <= next_bank_o;
      page_q <= next_page_o;
    end
  end

  assign bank_o = bank_q;
  assign page_o = page_q;

endmodule

// File: rtl/flash_region_attr_gen.sv
// flash_region_attr_gen: walks every (bank, page) pair after a start command.
// It presents one region attribute word per page over a valid/ready handshake.
// Ports:
//   clk_i, rst_ni             clock and asynchronous active-low reset
//   cfg_we_i, cfg_bank_i,
//   cfg_en_i                  bank enable register write port
//   start_i, phase_i          start a walk with the given phase (idle only)
//   attr_valid_o, attr_ready_i
//                             word handshake
//   attr_o                    {phase, cfg.en} of the current word
//   attr_bank_o, attr_page_o  index of the current word
//   busy_o                    walk in progress (WALK or DONE)
//   done_o                    one-cycle pulse after the last word
//   err_o                     one-cycle pulse on a rejected write or start
module flash_region_attr_gen import pkg::*; #(
  parameter int NumBanks     = pkg::NumBanks,
  parameter int PagesPerBank = pkg::PagesPerBank,
  parameter int BankW        = (NumBanks > 1) ? $clog2(NumBanks) : 1,
  parameter int PageW        = (PagesPerBank > 1) ? $clog2(PagesPerBank) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [BankW-1:0] cfg_bank_i,
  input  enum_t            cfg_en_i,
  input  logic             start_i,
  input  phase_t           phase_i,
  output logic             attr_valid_o,
  input  logic             attr_ready_i,
  output region_attr_t     attr_o,
  output logic [BankW-1:0] attr_bank_o,
  output logic [PageW-1:0] attr_page_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  phase_t           phase_q;
  enum_t            en_q [NumBanks];
  region_attr_t     attr_q;
  logic             valid_q;
  logic             err_q;

  logic             cfg_ok;
  logic             cfg_err;
  logic             start_ok;
  logic             start_err;
  logic             handshake;
  logic             walk_clear;
  logic             walk_advance;
  logic [BankW-1:0] next_bank;
  logic [PageW-1:0] next_page;
  logic             walk_last;

  // A write is only legal with a proper boolean code and an existing bank.
  assign cfg_ok    = ((cfg_en_i == true_e) || (cfg_en_i == false_e)) &&
                     (int'(cfg_bank_i) < NumBanks);
  assign cfg_err   = cfg_we_i && !cfg_ok;

  // Starts outside IDLE are silently dropped, so only idle starts can error.
  assign start_ok  = (state_q == IDLE) && start_i && (phase_i != invalid_e);
  assign start_err = (state_q == IDLE) && start_i && (phase_i == invalid_e);

  assign handshake    = valid_q && attr_ready_i;
  assign walk_clear   = start_ok;
  assign walk_advance = (state_q == WALK) && handshake && !walk_last;

  flash_page_walker #(
    .NumBanks     (NumBanks),
    .PagesPerBank (PagesPerBank),
    .BankW        (BankW),
    .PageW        (PageW)
  ) u_walker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (walk_clear),
    .advance_i   (walk_advance),
    .bank_o      (attr_bank_o),
    .page_o      (attr_page_o),
    .next_bank_o (next_bank),
    .next_page_o (next_page),
    .last_o      (walk_last)
  );

  // Enable registers. A word loaded on the same edge as a write reads the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBanks; i++) begin
        en_q[i] <= false_e;
      end
    end else if (cfg_we_i && cfg_ok) begin
      en_q[cfg_bank_i] <= cfg_en_i;
    end
  end

  // Error pulse for the cycle after the offending edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cfg_err || start_err;
    end
  end

  // Walk FSM and output word register.
  // The word for index k is loaded on the edge that moves the counters to k.
  // It is held until its handshake, so the bank/page outputs stay aligned with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= none_e;
      attr_q  <= AttrResetVal;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= WALK;
            phase_q <= phase_i;
            attr_q  <= make_attr(phase_i, en_q[0]);
            valid_q <= 1'b1;
          end
        end
        WALK: begin
          if (handshake) begin
            if (walk_last) begin
              valid_q <= 1'b0;
              state_q <= DONE;
            end else begin
              attr_q <= make_attr(phase_q, en_q[next_bank]);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign attr_valid_o = valid_q;
  assign attr_o       = attr_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;

  logic unused_next_page;
  assign unused_next_page = ^next_page;

endmodule

// File: tb/tb_flash_region_attr_gen.sv
// Self-checking bench for flash_region_attr_gen.
// Directed walks cover rma forcing, a plain seed walk with done timing,
// a randomly stalled walk, rejected writes and starts, a config write
// during a stall, and reset in the middle of a walk.
module tb_flash_region_attr_gen;
  import pkg::*;

  localparam int NB    = 2;
  localparam int PPB   = 64;
  localparam int BankW = 1;
  localparam int PageW = 6;

  logic             clk_i;
  logic             rst_ni;
  logic             cfg_we_i;
  logic [BankW-1:0] cfg_bank_i;
  enum_t            cfg_en_i;
  logic             start_i;
  phase_t           phase_i;
  logic             attr_valid_o;
  logic             attr_ready_i;
  region_attr_t     attr_o;
  logic [BankW-1:0] attr_bank_o;
  logic [PageW-1:0] attr_page_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  int total = 0;
  int bad   = 0;
  logic [3:0] en_model [NB];

  flash_region_attr_gen dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_bank_i   (cfg_bank_i),
    .cfg_en_i     (cfg_en_i),
    .start_i      (start_i),
    .phase_i      (phase_i),
    .attr_valid_o (attr_valid_o),
    .attr_ready_i (attr_ready_i),
    .attr_o       (attr_o),
    .attr_bank_o  (attr_bank_o),
    .attr_page_o  (attr_page_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single config write, and update of the bench model when the write is legal.
  task automatic applyConfig(input logic [BankW-1:0] b, input logic [3:0] v);
    @(posedge clk_i); #1;
    cfg_we_i   = 1'b1;
    cfg_bank_i = b;
    cfg_en_i   = enum_t'(v);
    @(posedge clk_i); #1;
    cfg_we_i   = 1'b0;
    if (v == 4'h6 || v == 4'h9) en_model[b] = v;
  endtask

  function automatic logic [31:0] packWord(input int b, input int p, input logic [5:0] a);
    return 32'(b) * 4096 + 32'(p) * 64 + 32'(a);
  endfunction

  // One complete walk. With wr_idx >= 0, the walk stalls on that word and
  // writes bank1 = true_e during the stall.
  task automatic runWalk(input phase_t ph, input bit stall, input int wr_idx, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] cur;
    logic [31:0] held;
    bit held_v;
    bit wr_done;
    int cyc, done_cnt, done_cyc, unstable, stall_left;
    held_v = 0; wr_done = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    unstable = 0; stall_left = 0; held = '0;

    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < PPB; p++) begin
        logic [3:0] e;
        e = en_model[b];
        if (wr_idx >= 0 && b == 1 && (b * PPB + p) > wr_idx) e = 4'h6;
        if (ph == rma_e) e = 4'h6;
        exp_q.push_back(packWord(b, p, {ph, e}));
      end
    end

    @(posedge clk_i); #1;
    start_i      = 1'b1;
    phase_i      = ph;
    attr_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 1000) begin
      @(negedge clk_i);
      cur = packWord(int'(attr_bank_o), int'(attr_page_o), attr_o);
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (attr_valid_o) begin
        if (held_v && cur != held) unstable++;
        if (attr_ready_i) begin
          got_q.push_back(cur);
          held_v = 0;
        end else begin
          held_v = 1;
          held   = cur;
        end
      end else begin
        if (held_v) unstable++;
        held_v = 0;
      end
      @(posedge clk_i); #1;
      start_i  = 1'b0;
      cfg_we_i = 1'b0;
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
      if (wr_idx >= 0 && !wr_done && attr_valid_o &&
          (int'(attr_bank_o) * PPB + int'(attr_page_o)) == wr_idx) begin
        cfg_we_i     = 1'b1;
        cfg_bank_i   = 1'b1;
        cfg_en_i     = true_e;
        attr_ready_i = 1'b0;
        stall_left   = 3;
        wr_done      = 1;
      end else if (stall_left > 0) begin
        attr_ready_i = 1'b0;
        stall_left--;
      end else begin
        attr_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    attr_ready_i = 1'b0;
    cfg_we_i     = 1'b0;
    if (wr_idx >= 0) en_model[1] = 4'h6;

    checkOutput({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_stable"}, 32'(unstable), 32'd0);
    checkOutput({tag, "_word_count"}, 32'(got_q.size()), 32'(NB * PPB));
    for (int k = 0; k < NB * PPB && k < got_q.size(); k++) begin
      checkOutput($sformatf("%s_word%0d", tag, k), got_q[k], exp_q[k]);
    end
    if (!stall && wr_idx < 0) checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'd129);
    checkOutput({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_valid_end"}, 32'(attr_valid_o), 32'd0);
  endtask

  initial begin
    bit reached;
    rst_ni       = 1'b0;
    cfg_we_i     = 1'b0;
    cfg_bank_i   = '0;
    cfg_en_i     = false_e;
    start_i      = 1'b0;
    phase_i      = seed_e;
    attr_ready_i = 1'b0;
    for (int i = 0; i < NB; i++) en_model[i] = 4'h9;

    #12;
    checkOutput("rst_valid", 32'(attr_valid_o), 32'd0);
    checkOutput("rst_busy",  32'(busy_o), 32'd0);
    checkOutput("rst_done",  32'(done_o), 32'd0);
    checkOutput("rst_err",   32'(err_o), 32'd0);
    checkOutput("rst_attr",  32'(attr_o), 32'h29);
    checkOutput("rst_bank",  32'(attr_bank_o), 32'd0);
    checkOutput("rst_page",  32'(attr_page_o), 32'd0);
    #10 rst_ni = 1'b1;

    $display("[TB] rma walk");
    applyConfig(1'b1, 4'h6);
    runWalk(rma_e, 1'b0, -1, "rma");

    $display("[TB] seed walk, ready high");
    applyConfig(1'b0, 4'h9);
    applyConfig(1'b1, 4'h6);
    runWalk(seed_e, 1'b0, -1, "seed");

    $display("[TB] seed walk, random stalls");
    runWalk(seed_e, 1'b1, -1, "stall");

    $display("[TB] rejected write and start");
    applyConfig(1'b0, 4'h3);
    checkOutput("badwr_err_pulse", 32'(err_o), 32'd1);
    @(posedge clk_i); #1;
    checkOutput("badwr_err_clear", 32'(err_o), 32'd0);
    start_i = 1'b1;
    phase_i = invalid_e;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    checkOutput("badstart_err_pulse", 32'(err_o), 32'd1);
    checkOutput("badstart_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("badstart_err_clear", 32'(err_o), 32'd0);
    checkOutput("badstart_busy_after", 32'(busy_o), 32'd0);
    checkOutput("badstart_valid", 32'(attr_valid_o), 32'd0);

    $display("[TB] config write during a stall on bank1 page5");
    applyConfig(1'b1, 4'h9);
    runWalk(seed_e, 1'b0, PPB + 5, "cfgwr");

    $display("[TB] reset at word 40");
    @(posedge clk_i); #1;
    start_i      = 1'b1;
    phase_i      = seed_e;
    attr_ready_i = 1'b1;
    reached      = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (attr_valid_o && attr_page_o == 6'd40) begin
        reached = 1;
        break;
      end
    end
    checkOutput("midrst_reach40", 32'(reached), 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(attr_valid_o), 32'd0);
    checkOutput("midrst_busy",  32'(busy_o), 32'd0);
    checkOutput("midrst_attr",  32'(attr_o), 32'h29);
    checkOutput("midrst_page",  32'(attr_page_o), 32'd0);
    checkOutput("midrst_bank",  32'(attr_bank_o), 32'd0);
    attr_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < NB; i++) en_model[i] = 4'h9;
    runWalk(seed_e, 1'b0, -1, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
